multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Moore-style FSM that sequences the shared multicycle MIPS datapath: program counter, instruction register, unified memory, register file and ALU.
- Supported instructions: R-type (add, sub, and, or, slt), lw, sw, beq and j.
- Drives every mux select, write enable, memory strobe and the 4-bit ALU control code.
- Sits between the instruction register (opcode/funct) and the datapath.

Parameters:
- HALT_ON_ILLEGAL, 1: 1 = an illegal opcode/funct enters HALT; 0 = it is treated as a NOP and the FSM returns to FETCH.

Ports:
- clock  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low.
- opcode  input  6  instr[31:26] from the instruction register.
- funct  input  6  instr[5:0] from the instruction register.
- zero  input  1  ALU zero flag, combinational in the current cycle.
- pc_write  output  1  PC load enable; includes the taken-branch term.
- ir_write  output  1  instruction register load.
- i_or_d  output  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_ren  output  1  memory read strobe.
- mem_wen  output  1  memory write strobe.
- reg_wen  output  1  register file write enable.
- reg_dst  output  1  write address select: 0 = rt, 1 = rd.
- mem_to_reg  output  1  write data select: 0 = ALUOut, 1 = MDR.
- alu_src_a  output  1  ALU A select: 0 = PC, 1 = rs.
- alu_src_b  output  2  ALU B select: 0 = rt, 1 = const 4, 2 = sign-extended imm, 3 = sign-extended imm<<2.
- alu_control  output  4  ALU op: 0 = AND, 1 = OR, 2 = ADD, 6 = SUB, 7 = SLT.
- pc_source  output  2  PC input select: 0 = ALU result, 1 = ALUOut, 2 = jump target.
- halted  output  1  high while in HALT.
- state  output  4  current state, for debug/verification.

Behaviour:
- Reset (reset = 0, asynchronous):
  - state = IDLE.
  - All outputs 0, including alu_control = 0 and state = IDLE encoding 0.
- Outputs are a pure function of registered state, except pc_write in BRANCH, which equals zero.
- Any output not listed for a state is 0.
- State encodings: IDLE 0, FETCH 1, DECODE 2, MEMADR 3, MEMRD 4, MEMWB 5, MEMWR 6, REX 7, RWB 8, BRANCH 9, JUMP 10, HALT 11.
- States, asserted outputs and transitions:
  - IDLE: all outputs 0 → FETCH. Gives exactly one dead cycle after reset release.
  - FETCH: mem_ren, ir_write, i_or_d = 0, alu_src_a = 0, alu_src_b = 1, alu_control = 2, pc_source = 0, pc_write (PC ← PC+4) → DECODE.
  - DECODE: alu_src_a = 0, alu_src_b = 3, alu_control = 2 (branch target into ALUOut). Next state:
    - opcode 35 or 43 → MEMADR.
    - opcode 0 with legal funct → REX.
    - opcode 4 → BRANCH.
    - opcode 2 → JUMP.
    - anything else → HALT (HALT_ON_ILLEGAL = 1) or FETCH (HALT_ON_ILLEGAL = 0).
  - MEMADR: alu_src_a = 1, alu_src_b = 2, alu_control = 2 → MEMRD if opcode 35, MEMWR if opcode 43.
  - MEMRD: mem_ren, i_or_d = 1 → MEMWB.
  - MEMWB: reg_wen, reg_dst = 0, mem_to_reg = 1 → FETCH.
  - MEMWR: mem_wen, i_or_d = 1 → FETCH.
  - REX: alu_src_a = 1, alu_src_b = 0, alu_control decoded from funct (32→2, 34→6, 36→0, 37→1, 42→7) → RWB.
  - RWB: reg_wen, reg_dst = 1, mem_to_reg = 0 → FETCH.
  - BRANCH: alu_src_a = 1, alu_src_b = 0, alu_control = 6, pc_source = 1, pc_write = zero → FETCH.
  - JUMP: pc_source = 2, pc_write → FETCH.
  - HALT: halted = 1, all strobes 0; held until reset.
- Instruction latency, FETCH to next FETCH: lw 5, sw 4, R-type 4, beq 3, j 3 cycles.
- Invariants:
  - mem_ren and mem_wen are never both 1 in any cycle.
  - mem_wen is high for exactly one cycle per sw.
  - reg_wen is high for exactly one cycle per lw/R-type; never for sw, beq or j.
  - pc_write is high at most twice per instruction (FETCH plus BRANCH/JUMP).
- opcode/funct are sampled only in DECODE, MEMADR and REX; the instruction register is stable there because ir_write is high only in FETCH.
- Reset mid-instruction, including during MEMWR or RWB: all strobes drop asynchronously in the same cycle, no partial write is completed, and the restart goes through IDLE.

Decomposition:
- Add to constants.h:
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J.
  - funct constants: FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT.
  - ALU control codes.
  - state encodings.
- One combinational sub-module, funct_decoder:
  - inputs: funct.
  - outputs: alu_control (4 bits) and legal (1 bit).
  - used both by the DECODE legality check and by REX.

Test Plan:
- reset release, opcode = 35 → IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH; mem_ren in FETCH and MEMRD, reg_wen only in MEMWB with mem_to_reg = 1.
- opcode = 43 → mem_wen high exactly one cycle (MEMWR) with i_or_d = 1; mem_ren = 0 that cycle; reg_wen never set; back to FETCH after 4 cycles.
- opcode = 0, funct = 42 → alu_control = 7 in REX; RWB reg_wen = 1, reg_dst = 1. Repeat with funct = 34 → alu_control = 6.
- opcode = 4, zero = 1 → pc_write = 1, pc_source = 1 in BRANCH. With zero = 0 → pc_write = 0. Both return to FETCH.
- opcode = 63, or opcode = 0 with funct = 0, HALT_ON_ILLEGAL = 1 → HALT, halted = 1, all strobes 0 for 20 cycles. With HALT_ON_ILLEGAL = 0 → DECODE goes to FETCH.
- reset pulsed low while in MEMWR → mem_wen falls asynchronously, state = 0, all outputs 0; after release, IDLE then FETCH.

Source files
------------

// File: rtl/multicycle_controller_pkg.sv
`default_nettype none
// ============================================================================
// multicycle_controller_pkg : opcodes, functs, ALU codes and FSM state encodings
// Revision 1.0
// ============================================================================
package multicycle_controller_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_J     = 6'd2;

    localparam logic [5:0] FN_ADD = 6'd32;
    localparam logic [5:0] FN_SUB = 6'd34;
    localparam logic [5:0] FN_AND = 6'd36;
    localparam logic [5:0] FN_OR  = 6'd37;
    localparam logic [5:0] FN_SLT = 6'd42;

    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;

    localparam logic [1:0] ALUB_RT      = 2'd0;
    localparam logic [1:0] ALUB_FOUR    = 2'd1;
    localparam logic [1:0] ALUB_IMM     = 2'd2;
    localparam logic [1:0] ALUB_IMM_SH2 = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_REX    = 4'd7,
        S_RWB    = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_HALT   = 4'd11
    } state_t;

endpackage
`default_nettype wire

// File: rtl/multicycle_controller_if.sv
`default_nettype none
// ============================================================================
// multicycle_controller_if : IR fields and zero flag in, datapath controls out
// Revision 1.0
// ============================================================================
interface multicycle_controller_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       pc_write;
    logic       ir_write;
    logic       i_or_d;
    logic       mem_ren;
    logic       mem_wen;
    logic       reg_wen;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_control;
    logic [1:0] pc_source;
    logic       halted;
    logic [3:0] state;

    modport master (
        input  opcode, funct, zero,
        output pc_write, ir_write, i_or_d, mem_ren, mem_wen, reg_wen, reg_dst,
               mem_to_reg, alu_src_a, alu_src_b, alu_control, pc_source, halted, state
    );

    modport slave (
        output opcode, funct, zero,
        input  pc_write, ir_write, i_or_d, mem_ren, mem_wen, reg_wen, reg_dst,
               mem_to_reg, alu_src_a, alu_src_b, alu_control, pc_source, halted, state
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_controller_funct_decoder.sv
`default_nettype none
// ============================================================================
// multicycle_controller_funct_decoder : R-type funct to ALU code plus legality
// Revision 1.0
// ============================================================================
module multicycle_controller_funct_decoder
    import multicycle_controller_pkg::*;
(
    input  logic [5:0] funct_i,
    output logic [3:0] alu_control_o,
    output logic       legal_o
);

    always_comb begin
        alu_control_o = ALU_AND;
        legal_o       = 1'b1;
        unique case (funct_i)
            FN_ADD:  alu_control_o = ALU_ADD;
            FN_SUB:  alu_control_o = ALU_SUB;
            FN_AND:  alu_control_o = ALU_AND;
            FN_OR:   alu_control_o = ALU_OR;
            FN_SLT:  alu_control_o = ALU_SLT;
            default: legal_o       = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// multicycle_controller : Moore FSM sequencing the multicycle MIPS datapath
// Revision 1.0
// ============================================================================
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic                   clock,
    input  logic                   reset,
    multicycle_controller_if.master bus
);

    state_t     state_q;
    state_t     state_d;
    logic [3:0] fn_alu_control;
    logic       fn_legal;
    state_t     illegal_next;

    multicycle_controller_funct_decoder u_funct_decoder (
        .funct_i       (bus.funct),
        .alu_control_o (fn_alu_control),
        .legal_o       (fn_legal)
    );

    assign illegal_next = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;

    // Async clear forces IDLE, so every strobe drops the moment reset falls.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d         = state_q;
        bus.pc_write    = 1'b0;
        bus.ir_write    = 1'b0;
        bus.i_or_d      = 1'b0;
        bus.mem_ren     = 1'b0;
        bus.mem_wen     = 1'b0;
        bus.reg_wen     = 1'b0;
        bus.reg_dst     = 1'b0;
        bus.mem_to_reg  = 1'b0;
        bus.alu_src_a   = 1'b0;
        bus.alu_src_b   = ALUB_RT;
        bus.alu_control = ALU_AND;
        bus.pc_source   = PCSRC_ALU;
        bus.halted      = 1'b0;
        bus.state       = state_q;
        unique case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                bus.mem_ren     = 1'b1;
                bus.ir_write    = 1'b1;
                bus.alu_src_b   = ALUB_FOUR;
                bus.alu_control = ALU_ADD;
                bus.pc_write    = 1'b1;
                state_d         = S_DECODE;
            end
            S_DECODE: begin
                bus.alu_src_b   = ALUB_IMM_SH2;
                bus.alu_control = ALU_ADD;
                unique case (bus.opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = fn_legal ? S_REX : illegal_next;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = illegal_next;
                endcase
            end
            S_MEMADR: begin
                bus.alu_src_a   = 1'b1;
                bus.alu_src_b   = ALUB_IMM;
                bus.alu_control = ALU_ADD;
                state_d         = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                bus.mem_ren = 1'b1;
                bus.i_or_d  = 1'b1;
                state_d     = S_MEMWB;
            end
            S_MEMWB: begin
                bus.reg_wen    = 1'b1;
                bus.mem_to_reg = 1'b1;
                state_d        = S_FETCH;
            end
            S_MEMWR: begin
                bus.mem_wen = 1'b1;
                bus.i_or_d  = 1'b1;
                state_d     = S_FETCH;
            end
            S_REX: begin
                bus.alu_src_a   = 1'b1;
                bus.alu_control = fn_alu_control;
                state_d         = S_RWB;
            end
            S_RWB: begin
                bus.reg_wen = 1'b1;
                bus.reg_dst = 1'b1;
                state_d     = S_FETCH;
            end
            S_BRANCH: begin
                bus.alu_src_a   = 1'b1;
                bus.alu_control = ALU_SUB;
                bus.pc_source   = PCSRC_ALUOUT;
                bus.pc_write    = bus.zero;
                state_d         = S_FETCH;
            end
            S_JUMP: begin
                bus.pc_source = PCSRC_JUMP;
                bus.pc_write  = 1'b1;
                state_d       = S_FETCH;
            end
            S_HALT: begin
                bus.halted = 1'b1;
                state_d    = S_HALT;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
// tb_multicycle_controller : directed sequence checks for both HALT_ON_ILLEGAL settings
// Revision 1.0
// ============================================================================
module tb_multicycle_controller;

    // Vector layout: {state, pc_write, ir_write, i_or_d, mem_ren, mem_wen, reg_wen,
    //                 reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_control, pc_source, halted}
    localparam logic [21:0] E_IDLE    = {4'd0,  9'b000000000, 2'd0, 4'd0, 2'd0, 1'b0};
    localparam logic [21:0] E_FETCH   = {4'd1,  9'b110100000, 2'd1, 4'd2, 2'd0, 1'b0};
    localparam logic [21:0] E_DECODE  = {4'd2,  9'b000000000, 2'd3, 4'd2, 2'd0, 1'b0};
    localparam logic [21:0] E_MEMADR  = {4'd3,  9'b000000001, 2'd2, 4'd2, 2'd0, 1'b0};
    localparam logic [21:0] E_MEMRD   = {4'd4,  9'b001100000, 2'd0, 4'd0, 2'd0, 1'b0};
    localparam logic [21:0] E_MEMWB   = {4'd5,  9'b000001010, 2'd0, 4'd0, 2'd0, 1'b0};
    localparam logic [21:0] E_MEMWR   = {4'd6,  9'b001010000, 2'd0, 4'd0, 2'd0, 1'b0};
    localparam logic [21:0] E_REX_SLT = {4'd7,  9'b000000001, 2'd0, 4'd7, 2'd0, 1'b0};
    localparam logic [21:0] E_REX_SUB = {4'd7,  9'b000000001, 2'd0, 4'd6, 2'd0, 1'b0};
    localparam logic [21:0] E_RWB     = {4'd8,  9'b000001100, 2'd0, 4'd0, 2'd0, 1'b0};
    localparam logic [21:0] E_BR_T    = {4'd9,  9'b100000001, 2'd0, 4'd6, 2'd1, 1'b0};
    localparam logic [21:0] E_BR_N    = {4'd9,  9'b000000001, 2'd0, 4'd6, 2'd1, 1'b0};
    localparam logic [21:0] E_JUMP    = {4'd10, 9'b100000000, 2'd0, 4'd0, 2'd2, 1'b0};
    localparam logic [21:0] E_HALT    = {4'd11, 9'b000000000, 2'd0, 4'd0, 2'd0, 1'b1};

    logic clock;
    logic reset;
    int   total;
    int   bad;

    multicycle_controller_if bus_h ();
    multicycle_controller_if bus_n ();

    multicycle_controller #(.HALT_ON_ILLEGAL(1'b1)) dut_h (
        .clock (clock),
        .reset (reset),
        .bus   (bus_h)
    );

    multicycle_controller #(.HALT_ON_ILLEGAL(1'b0)) dut_n (
        .clock (clock),
        .reset (reset),
        .bus   (bus_n)
    );

    wire [21:0] obs_h = {bus_h.state, bus_h.pc_write, bus_h.ir_write, bus_h.i_or_d,
                         bus_h.mem_ren, bus_h.mem_wen, bus_h.reg_wen, bus_h.reg_dst,
                         bus_h.mem_to_reg, bus_h.alu_src_a, bus_h.alu_src_b,
                         bus_h.alu_control, bus_h.pc_source, bus_h.halted};
    wire [21:0] obs_n = {bus_n.state, bus_n.pc_write, bus_n.ir_write, bus_n.i_or_d,
                         bus_n.mem_ren, bus_n.mem_wen, bus_n.reg_wen, bus_n.reg_dst,
                         bus_n.mem_to_reg, bus_n.alu_src_a, bus_n.alu_src_b,
                         bus_n.alu_control, bus_n.pc_source, bus_n.halted};

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic z);
        bus_h.opcode = op; bus_h.funct = fn; bus_h.zero = z;
        bus_n.opcode = op; bus_n.funct = fn; bus_n.zero = z;
    endtask

    // Ends one cycle into FETCH with both instances in lockstep.
    task automatic test_reset();
        #2 reset = 1'b0;
        #1;
        total++;
        if (obs_h !== 22'd0 || obs_n !== 22'd0) begin
            bad++;
            $display("FAIL reset_async: got %h/%h want %h", obs_h, obs_n, 22'd0);
        end
        step();
        total++;
        if (obs_h !== E_IDLE || obs_n !== E_IDLE) begin
            bad++;
            $display("FAIL reset_held: got %h/%h want %h", obs_h, obs_n, E_IDLE);
        end
        reset = 1'b1;
        #1;
        total++;
        if (obs_h !== E_IDLE || obs_n !== E_IDLE) begin
            bad++;
            $display("FAIL reset_idle: got %h/%h want %h", obs_h, obs_n, E_IDLE);
        end
        step();
        total++;
        if (obs_h !== E_FETCH || obs_n !== E_FETCH) begin
            bad++;
            $display("FAIL reset_fetch: got %h/%h want %h", obs_h, obs_n, E_FETCH);
        end
    endtask

    task automatic test_lw();
        logic [21:0] exp [0:4];
        exp = '{E_DECODE, E_MEMADR, E_MEMRD, E_MEMWB, E_FETCH};
        drive(6'd35, 6'd0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            total++;
            if (obs_h !== exp[i] || obs_n !== exp[i]) begin
                bad++;
                $display("FAIL lw cycle %0d: got %h/%h want %h", i, obs_h, obs_n, exp[i]);
            end
        end
    endtask

    task automatic test_sw();
        logic [21:0] exp [0:3];
        exp = '{E_DECODE, E_MEMADR, E_MEMWR, E_FETCH};
        drive(6'd43, 6'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if (obs_h !== exp[i] || obs_n !== exp[i]) begin
                bad++;
                $display("FAIL sw cycle %0d: got %h/%h want %h", i, obs_h, obs_n, exp[i]);
            end
        end
    endtask

    task automatic test_rtype(input logic [5:0] fn, input logic [21:0] rex);
        logic [21:0] exp [0:3];
        exp = '{E_DECODE, rex, E_RWB, E_FETCH};
        drive(6'd0, fn, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if (obs_h !== exp[i] || obs_n !== exp[i]) begin
                bad++;
                $display("FAIL rtype fn=%0d cycle %0d: got %h/%h want %h",
                         fn, i, obs_h, obs_n, exp[i]);
            end
        end
    endtask

    task automatic test_beq(input logic z);
        logic [21:0] exp [0:2];
        exp = '{E_DECODE, z ? E_BR_T : E_BR_N, E_FETCH};
        drive(6'd4, 6'd0, z);
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (obs_h !== exp[i] || obs_n !== exp[i]) begin
                bad++;
                $display("FAIL beq zero=%0d cycle %0d: got %h/%h want %h",
                         z, i, obs_h, obs_n, exp[i]);
            end
        end
        drive(6'd0, 6'd32, 1'b0);
    endtask

    task automatic test_jump();
        logic [21:0] exp [0:2];
        exp = '{E_DECODE, E_JUMP, E_FETCH};
        drive(6'd2, 6'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (obs_h !== exp[i] || obs_n !== exp[i]) begin
                bad++;
                $display("FAIL jump cycle %0d: got %h/%h want %h", i, obs_h, obs_n, exp[i]);
            end
        end
    endtask

    task automatic test_illegal(input logic [5:0] op, input logic [5:0] fn);
        drive(op, fn, 1'b0);
        step();
        total++;
        if (obs_h !== E_DECODE || obs_n !== E_DECODE) begin
            bad++;
            $display("FAIL illegal op=%0d decode: got %h/%h want %h", op, obs_h, obs_n, E_DECODE);
        end
        step();
        total++;
        if (obs_n !== E_FETCH) begin
            bad++;
            $display("FAIL illegal op=%0d nop_fetch: got %h want %h", op, obs_n, E_FETCH);
        end
        for (int i = 0; i < 20; i++) begin
            total++;
            if (obs_h !== E_HALT) begin
                bad++;
                $display("FAIL illegal op=%0d halt cycle %0d: got %h want %h",
                         op, i, obs_h, E_HALT);
            end
            step();
        end
        test_reset();
    endtask

    task automatic test_reset_memwr();
        drive(6'd43, 6'd0, 1'b0);
        step();
        step();
        step();
        total++;
        if (obs_h !== E_MEMWR || obs_n !== E_MEMWR) begin
            bad++;
            $display("FAIL rst_memwr pre: got %h/%h want %h", obs_h, obs_n, E_MEMWR);
        end
        #1 reset = 1'b0;
        #1;
        total++;
        if (bus_h.mem_wen !== 1'b0 || bus_n.mem_wen !== 1'b0) begin
            bad++;
            $display("FAIL rst_memwr wen_drop: got %b/%b want 0",
                     bus_h.mem_wen, bus_n.mem_wen);
        end
        total++;
        if (obs_h !== E_IDLE || obs_n !== E_IDLE) begin
            bad++;
            $display("FAIL rst_memwr outputs: got %h/%h want %h", obs_h, obs_n, E_IDLE);
        end
        test_reset();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        drive(6'd0, 6'd0, 1'b0);
        test_reset();
        test_lw();
        test_sw();
        test_rtype(6'd42, E_REX_SLT);
        test_rtype(6'd34, E_REX_SUB);
        test_beq(1'b1);
        test_beq(1'b0);
        test_jump();
        test_lw();
        test_illegal(6'd63, 6'd0);
        test_illegal(6'd0, 6'd0);
        test_reset_memwr();
        test_sw();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
